// File: rtl/md_pkg.sv
// Shared MD-unit definitions: op encodings, FSM state encoding, HI/LO pair type and op helpers.
// Pure declarations; no timing or flow-control implications.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'b0000;
  localparam logic [3:0] MD_MULT  = 4'b0001;
  localparam logic [3:0] MD_MULTU = 4'b0010;
  localparam logic [3:0] MD_DIV   = 4'b0011;
  localparam logic [3:0] MD_DIVU  = 4'b0100;
  localparam logic [3:0] MD_MTHI  = 4'b0101;
  localparam logic [3:0] MD_MTLO  = 4'b0110;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // True for the multi-cycle ops that occupy the unit (and must stall on BUSY).
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO; MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES, MTHI/MTLO single edge.
// No backpressure of its own: START while BUSY is dropped, STALL tells the hazard unit to hold the instruction.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic [3:0]  MDop,
  input  logic        START,
  output logic        BUSY,
  output logic        STALL,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          div_zero_q;
  hilo_t         hilo_q;
  hilo_t         hilo_tmp;

  hilo_t        res;
  logic         div_zero;
  logic         sdiv_ovf;
  logic [31:0]  b_udiv;
  logic [31:0]  b_sdiv;
  logic [63:0]  a_sext;
  logic [63:0]  b_sext;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;

  assign div_zero = (SRCB == 32'd0);
  assign sdiv_ovf = (SRCA == 32'h8000_0000) && (SRCB == 32'hFFFF_FFFF);

  // Dividing by 1 instead yields exactly the required MIN/-1 result (q=MIN, r=0)
  // and keeps the divider defined for a zero divisor, whose result is discarded anyway.
  assign b_udiv = div_zero ? 32'd1 : SRCB;
  assign b_sdiv = (div_zero || sdiv_ovf) ? 32'd1 : SRCB;

  assign a_sext = {{32{SRCA[31]}}, SRCA};
  assign b_sext = {{32{SRCB[31]}}, SRCB};
  assign quo_s  = $signed(SRCA) / $signed(b_sdiv);
  assign rem_s  = $signed(SRCA) % $signed(b_sdiv);

  always_comb begin
    res = '0;
    case (MDop)
      MD_MULT:  res = a_sext * b_sext;
      MD_MULTU: res = {32'd0, SRCA} * {32'd0, SRCB};
      MD_DIV: begin
        res.lo = quo_s;
        res.hi = rem_s;
      end
      MD_DIVU: begin
        res.lo = SRCA / b_udiv;
        res.hi = SRCA % b_udiv;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hilo_q     <= '0;
      hilo_tmp   <= '0;
    end else if (state == ST_IDLE) begin
      if (START) begin
        if (is_md_op(MDop)) begin
          hilo_tmp   <= res;
          div_zero_q <= is_div_op(MDop) && div_zero;
          cnt        <= is_div_op(MDop) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          busy_q     <= 1'b1;
          state      <= ST_RUN;
        end else if (MDop == MD_MTHI) begin
          hilo_q.hi <= SRCA;
        end else if (MDop == MD_MTLO) begin
          hilo_q.lo <= SRCA;
        end
      end
    end else begin
      if (cnt == '0) begin
        if (!div_zero_q) hilo_q <= hilo_tmp;
        busy_q <= 1'b0;
        state  <= ST_IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign BUSY  = busy_q;
  assign STALL = busy_q | (START & is_md_op(MDop));
  assign HI    = hilo_q.hi;
  assign LO    = hilo_q.lo;

endmodule
